riscv_instr_mem_responder: RTL
==============================

RISCV_INSTR_MEM_RESPONDER -- requirements
Module: riscv_instr_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the internal instruction array.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address mapped to word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0..7, meaning the extra cycles between grant and response.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, range 1..4, meaning the number of granted but unanswered requests allowed.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port instr_req_i, input, 1 bit: the fetch request from the initiator.
REQ-008 SHALL have port instr_addr_i, input, 32 bits: the fetch byte address.
REQ-009 SHALL have port instr_gnt_o, output, 1 bit: the request is accepted this cycle.
REQ-010 SHALL have port instr_rvalid_o, output, 1 bit: the response is valid this cycle.
REQ-011 SHALL have port instr_rdata_o, output, 32 bits: the response data.
REQ-012 SHALL have port instr_err_o, output, 1 bit: the response is an access fault; it drives the initiator's instr_err_pmp_i.
REQ-013 SHALL have port gnt_stall_i, input, 1 bit: the bench forces the grant low.
REQ-014 SHALL have ports load_we_i (input, 1 bit), load_addr_i (input, $clog2(DEPTH_WORDS) bits) and load_wdata_i (input, 32 bits), meaning the preload write port addressed by word index.
REQ-015 SHALL have port busy_o, output, 1 bit: at least one request is outstanding.

Function
REQ-016 instr_gnt_o SHALL be the combinational AND of: instr_req_i, ~gnt_stall_i, and (outstanding count < MAX_OUTSTANDING); it is never high without a request.
REQ-017 On each grant in cycle T, an entry {addr, err, cnt=WAIT_STATES} SHALL be pushed into an in-order response FIFO of depth MAX_OUTSTANDING; the entry is visible from T+1.
REQ-018 Every entry with cnt>0 SHALL decrement cnt by 1 each cycle, all entries in parallel.
REQ-019 instr_rvalid_o SHALL be high exactly when the FIFO head is valid and its cnt==0; the head is popped that cycle, and at most one response is returned per cycle.
REQ-020 Latency: the response to a grant at cycle T SHALL arrive no earlier than T+1+WAIT_STATES, and no earlier than the cycle after the previous response; responses SHALL return in grant order.
REQ-021 A grant and a pop in the same cycle SHALL both take effect, leaving the outstanding count unchanged; when full, a pop in cycle T SHALL allow a grant only from T+1 (the count is registered).
REQ-022 err SHALL be 1 when addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH_WORDS, with no wrap: the sum is computed at 33 bits.
REQ-023 On response with err=0, instr_rdata_o SHALL equal mem[(addr-BASE_ADDR)>>2]; addr[1:0] is ignored.
REQ-024 instr_rdata_o SHALL be 0 when instr_rvalid_o is low or when err=1.
REQ-025 instr_err_o SHALL equal the head err while instr_rvalid_o is high, and 0 otherwise.
REQ-026 The array SHALL be read at pop time; a load write to the same word in the same cycle SHALL update the array at the clock edge, so the response returns the old data.
REQ-027 Load writes SHALL be accepted every cycle, independent of fetch traffic.
REQ-028 busy_o SHALL equal (outstanding count != 0).
REQ-029 The outstanding count width SHALL be $clog2(MAX_OUTSTANDING+1) bits; it SHALL never exceed MAX_OUTSTANDING or go below 0.

Reset
REQ-030 While rst_n is low at a rising edge, the FIFO SHALL empty and all counts clear; instr_rvalid_o, instr_err_o, busy_o and instr_rdata_o SHALL then read 0.
REQ-031 Requests outstanding at reset SHALL be discarded; no response for them SHALL ever appear.
REQ-032 While reset is asserted, instr_gnt_o SHALL be 0.
REQ-033 Array contents SHALL NOT be cleared by reset.

Verification
REQ-034 With WAIT_STATES=0, preload mem[0]=32'h0000_0013, req addr 0x0 granted at T -> rvalid=1 with rdata=32'h0000_0013 and err=0 at T+1.
REQ-035 With WAIT_STATES=2 and MAX_OUTSTANDING=2, back-to-back reqs to 0x0 and 0x4 -> grants at T and T+1, no grant at T+2, responses in order at T+3 and T+4.
REQ-036 Req to BASE_ADDR+4*DEPTH_WORDS (0x1000 at defaults) -> gnt=1, then one cycle later rvalid=1, err=1, rdata=0.
REQ-037 gnt_stall_i=1 for 3 cycles with req held -> gnt=0 and busy_o=0 for those 3 cycles; grant in the first cycle after the stall drops.
REQ-038 rst_n low for 1 cycle while 2 requests are outstanding -> no rvalid thereafter, busy_o=0, and a subsequent request is served normally.
REQ-039 Load write mem[1]=32'hDEAD_BEEF in the same cycle as the pop for 0x4 (old value 0) -> rdata=0; the next fetch of 0x4 returns 32'hDEAD_BEEF.

Source files
------------

// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch memory model: grants fetch requests, returns them in order after a
// programmable wait, and flags addresses outside the array as access faults.
module riscv_instr_mem_responder #(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned WAIT_STATES     = 0,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           instr_req_i,
    input  logic [31:0]                    instr_addr_i,
    output logic                           instr_gnt_o,
    output logic                           instr_rvalid_o,
    output logic [31:0]                    instr_rdata_o,
    output logic                           instr_err_o,
    input  logic                           gnt_stall_i,
    input  logic                           load_we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                    load_wdata_i,
    output logic                           busy_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    // One past the last mapped byte, kept at 33 bits so a high BASE_ADDR cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0]                r_mem [DEPTH_WORDS];
    logic [PW-1:0]              r_rd_ptr;
    logic [PW-1:0]              r_wr_ptr;
    logic [CW-1:0]              r_count;

    logic [2:0]                 w_cnt [MAX_OUTSTANDING];
    logic [AW-1:0]              w_idx [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] w_err;
    logic                       w_gnt;
    logic                       w_pop;
    logic                       w_req_err;
    logic [AW-1:0]              w_req_idx;
    logic                       w_head_err;
    logic [AW-1:0]              w_head_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_req_err = ({1'b0, instr_addr_i} < {1'b0, BASE_ADDR}) || ({1'b0, instr_addr_i} >= LIMIT);
    assign w_req_idx = AW'((instr_addr_i - BASE_ADDR) >> 2);

    assign w_gnt = rst_n & instr_req_i & ~gnt_stall_i & (r_count < CW'(MAX_OUTSTANDING));
    assign w_pop = rst_n & (r_count != '0) & (w_cnt[r_rd_ptr] == 3'd0);

    assign w_head_err = w_err[r_rd_ptr];
    assign w_head_idx = w_idx[r_rd_ptr];

    // Each FIFO slot owns its own countdown so every waiting entry ages in parallel.
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_entry
        logic          r_err;
        logic [2:0]    r_cnt;
        logic [AW-1:0] r_idx;
        logic          w_push_here;

        assign w_push_here = w_gnt && (r_wr_ptr == PW'(gi));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_err <= 1'b0;
                r_cnt <= 3'd0;
                r_idx <= '0;
            end else if (w_push_here) begin
                r_err <= w_req_err;
                r_cnt <= 3'(WAIT_STATES);
                r_idx <= w_req_idx;
            end else if (r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end

        assign w_cnt[gi] = r_cnt;
        assign w_idx[gi] = r_idx;
        assign w_err[gi] = r_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_gnt) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_gnt) - CW'(w_pop);
        end
    end

    // Preload port is never reset; a same-cycle write lands after the pop reads old data.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            r_mem[load_addr_i] <= load_wdata_i;
        end
    end

    assign instr_gnt_o    = w_gnt;
    assign instr_rvalid_o = w_pop;
    assign instr_err_o    = w_pop & w_head_err;
    assign instr_rdata_o  = (w_pop && !w_head_err) ? r_mem[w_head_idx] : 32'h0;
    assign busy_o         = (r_count != '0);

endmodule
